// File: rtl/present_encryptor_ctrl_if.sv
// Stream interface of the PRESENT-80 sequencing wrapper: key/plaintext
// request channel in, ciphertext response channel out, both valid/ready.
interface present_encryptor_ctrl_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [79:0] key_i;
    logic [63:0] pt_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] ct_o;

    // Environment side: offers key/plaintext pairs and consumes ciphertexts.
    modport master (
        output in_valid_i, key_i, pt_i, out_ready_i,
        input  in_ready_o, out_valid_o, ct_o
    );

    // Controller side.
    modport slave (
        input  in_valid_i, key_i, pt_i, out_ready_i,
        output in_ready_o, out_valid_o, ct_o
    );
endinterface

// File: rtl/present_encryptor_ctrl.sv
// Sequencing/handshake wrapper for an iterative PRESENT-80 core. Loads the
// key and then the plaintext over the core's shared 80-bit load bus, lets the
// core iterate ROUNDS times, captures data_o as the ciphertext and holds it
// until the consumer takes it. The key is reloaded for every block because
// the core destroys its copy while running.
module present_encryptor_ctrl #(
    parameter int unsigned ROUNDS = 31
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    present_encryptor_ctrl_if.slave        bus,
    output logic                           busy_o,
    output logic [79:0]                    enc_data_o,
    output logic                           enc_key_load_o,
    output logic                           enc_data_load_o,
    input  logic [63:0]                    enc_data_i
);

    localparam logic [4:0] LAST_CNT = 5'(ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_KEY  = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    state_e      state_r;
    state_e      state_s;
    logic [63:0] pt_r;
    logic [4:0]  cnt_r;
    logic [63:0] ct_r;
    logic        out_valid_r;
    logic        in_ready_r;
    logic        busy_r;
    logic        key_load_r;
    logic        data_load_r;
    logic [79:0] enc_data_r;

    logic        accept_s;
    logic        last_round_s;
    logic        out_hs_s;
    logic        in_ready_s;
    logic        busy_s;
    logic        key_load_s;
    logic        data_load_s;
    logic [79:0] enc_data_s;

    // Next-state logic and the one-cycle events that steer the datapath.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        last_round_s = 1'b0;
        out_hs_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid_i && in_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_LOAD_KEY;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_LOAD_KEY:  state_s = ST_LOAD_DATA;
            ST_LOAD_DATA: state_s = ST_RUN;
            ST_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    last_round_s = 1'b1;
                    state_s      = ST_DONE;
                end else begin
                    state_s      = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready_i) begin
                    out_hs_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    state_s  = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so every output is a flop.
    // LOAD_KEY is only entered on an accept, so the key comes straight from
    // the port; the load-bus register then holds it as the latched key.
    always_comb begin
        in_ready_s  = 1'b0;
        busy_s      = 1'b0;
        key_load_s  = 1'b0;
        data_load_s = 1'b0;
        enc_data_s  = 80'h0;
        case (state_s)
            ST_IDLE: in_ready_s = 1'b1;
            ST_LOAD_KEY: begin
                busy_s     = 1'b1;
                key_load_s = 1'b1;
                enc_data_s = bus.key_i;
            end
            ST_LOAD_DATA: begin
                busy_s      = 1'b1;
                data_load_s = 1'b1;
                enc_data_s  = {16'h0000, pt_r};
            end
            ST_RUN:  busy_s = 1'b1;
            ST_DONE: busy_s = 1'b0;
            default: busy_s = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered control outputs toward the requester and the core.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            key_load_r  <= 1'b0;
            data_load_r <= 1'b0;
            enc_data_r  <= 80'h0;
        end else begin
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            key_load_r  <= key_load_s;
            data_load_r <= data_load_s;
            enc_data_r  <= enc_data_s;
        end
    end

    // Plaintext latch, round counter, ciphertext capture and output valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pt_r        <= 64'h0;
            cnt_r       <= 5'd0;
            ct_r        <= 64'h0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                pt_r <= bus.pt_i;
            end
            if (state_r == ST_LOAD_DATA) begin
                cnt_r <= 5'd0;
            end else if (state_r == ST_RUN) begin
                cnt_r <= cnt_r + 5'd1;
            end
            if (last_round_s) begin
                ct_r        <= enc_data_i;
                out_valid_r <= 1'b1;
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o  = in_ready_r;
    assign bus.out_valid_o = out_valid_r;
    assign bus.ct_o        = ct_r;
    assign busy_o          = busy_r;
    assign enc_data_o      = enc_data_r;
    assign enc_key_load_o  = key_load_r;
    assign enc_data_load_o = data_load_r;

endmodule

// File: tb/tb_present_encryptor_ctrl.sv
// Bench for present_encryptor_ctrl with a behavioural PRESENT-80 core attached.
// A driver pushes the expected ciphertext on every accept; a negedge monitor
// pops and compares on every output handshake and checks the core strobes.
module tb_present_encryptor_ctrl;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    present_encryptor_ctrl_if bus_if ();

    logic        busy_o;
    logic [79:0] enc_data_o;
    logic        enc_key_load_o;
    logic        enc_data_load_o;
    logic [63:0] enc_data_i;

    present_encryptor_ctrl #(.ROUNDS(31)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .bus             (bus_if),
        .busy_o          (busy_o),
        .enc_data_o      (enc_data_o),
        .enc_key_load_o  (enc_key_load_o),
        .enc_data_load_o (enc_data_load_o),
        .enc_data_i      (enc_data_i)
    );

    // ---------------- behavioural PRESENT-80 core ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[x*4 +: 4];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = sbox(s[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 63; i++) r[(i*16) % 63] = s[i];
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    logic [63:0] core_state = 64'h0;
    logic [79:0] core_key   = 80'h0;
    logic [4:0]  core_rc    = 5'd1;

    // Core: load key / load state / one round per cycle.
    always @(posedge clk_i) begin
        if (enc_key_load_o) begin
            core_key <= enc_data_o;
            core_rc  <= 5'd1;
        end else if (enc_data_load_o) begin
            core_state <= enc_data_o[63:0];
        end else begin
            core_state <= p_layer(s_layer(core_state ^ core_key[79:16]));
            core_key   <= key_upd(core_key, core_rc);
            core_rc    <= core_rc + 5'd1;
        end
    end
    assign enc_data_i = core_state ^ core_key[79:16];

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] ct;
        int          acc;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Edge counter used to time accepts and output rises.
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [63:0] held_ct    = 64'h0;
    int          kl_cnt     = 0;
    int          dl_cnt     = 0;
    exp_t        mon_e;

    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            kl_cnt     = 0;
            dl_cnt     = 0;
        end else begin
            check("strobe_exclusive", 80'(enc_key_load_o & enc_data_load_o), 80'd0);
            check("load_bus_idle_zero",
                  (enc_key_load_o || enc_data_load_o) ? 80'd0 : enc_data_o, 80'd0);
            if (enc_key_load_o)  kl_cnt++;
            if (enc_data_load_o) dl_cnt++;
            if (bus_if.out_valid_o && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 80'd1, 80'd0);
                end else begin
                    check("latency", 80'(cyc - sb_q[0].acc), 80'd34);
                end
                check("key_load_per_block", 80'(kl_cnt), 80'd1);
                check("data_load_per_block", 80'(dl_cnt), 80'd1);
                kl_cnt  = 0;
                dl_cnt  = 0;
                held_ct = bus_if.ct_o;
            end
            if (bus_if.out_valid_o && prev_valid) begin
                check("ct_stable", 80'(bus_if.ct_o), 80'(held_ct));
                check("in_ready_in_done", 80'(bus_if.in_ready_o), 80'd0);
                check("valid_after_handshake", 80'(prev_ready), 80'd0);
            end
            if (bus_if.out_valid_o && bus_if.out_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("pop_empty", 80'd1, 80'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("ciphertext", 80'(bus_if.ct_o), 80'(mon_e.ct));
                end
            end
            prev_valid = bus_if.out_valid_o;
            prev_ready = bus_if.out_ready_i;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer a pair until accepted; the expected ciphertext is queued at the
    // accepting edge, then the inputs are scrambled to prove sampling.
    task automatic send(input logic [79:0] k, input logic [63:0] p,
                        input logic [63:0] exp_ct, output int acc);
        exp_t e;
        bit   done;
        done = 1'b0;
        acc  = -1;
        bus_if.in_valid_i = 1'b1;
        bus_if.key_i      = k;
        bus_if.pt_i       = p;
        for (int n = 0; n < 400 && !done; n++) begin
            if (bus_if.in_ready_o) begin
                tick();
                acc   = cyc;
                e.ct  = exp_ct;
                e.acc = acc;
                sb_q.push_back(e);
                done  = 1'b1;
            end else begin
                tick();
            end
        end
        if (!done) check("accept_timeout", 80'd1, 80'd0);
        bus_if.in_valid_i = 1'b0;
        bus_if.key_i      = ~k;
        bus_if.pt_i       = ~p;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !bus_if.in_ready_o) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", 80'(n >= 200), 80'd0);
    endtask

    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] K1 = 80'hFFFFFFFFFFFFFFFFFFFF;
    localparam logic [63:0] P0 = 64'h0;
    localparam logic [63:0] P1 = 64'hFFFFFFFFFFFFFFFF;

    int a0, a1, a2, a3, a4, hs_edge, wn;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid_i  = 1'b0;
        bus_if.key_i       = 80'h0;
        bus_if.pt_i        = 64'h0;
        bus_if.out_ready_i = 1'b1;
        #1;
        check("rst_in_ready",  80'(bus_if.in_ready_o),  80'd0);
        check("rst_out_valid", 80'(bus_if.out_valid_o), 80'd0);
        check("rst_ct",        80'(bus_if.ct_o),        80'd0);
        check("rst_busy",      80'(busy_o),             80'd0);
        check("rst_enc_data",  enc_data_o,              80'd0);
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();

        // Zero key/plaintext.
        send(K0, P0, 64'h5579C1387B228445, a0);
        drain();

        // Single-value vectors, issued back to back: accepts 36 edges apart
        // (LOAD_KEY, LOAD_DATA, 32 RUN, DONE, IDLE).
        send(K1, P0, 64'hE72C46C0F5945049, a0);
        send(K0, P1, 64'hA112FFC72F68417B, a1);
        check("gap_1", 80'(a1 - a0), 80'd36);
        send(K1, P1, 64'h3333DCD3213210D2, a2);
        check("gap_2", 80'(a2 - a1), 80'd36);
        send(K0, P0, 64'h5579C1387B228445, a3);
        check("gap_3", 80'(a3 - a2), 80'd36);
        drain();

        // Backpressure: consumer stalls 50 cycles while a second pair waits.
        bus_if.out_ready_i = 1'b0;
        hs_edge = 0;
        fork
            begin
                send(K0, P1, 64'hA112FFC72F68417B, a0);
                send(K1, P0, 64'hE72C46C0F5945049, a4);
            end
            begin
                wn = 0;
                while (!bus_if.out_valid_o && wn < 200) begin
                    tick();
                    wn++;
                end
                check("bp_valid_seen", 80'(bus_if.out_valid_o), 80'd1);
                repeat (50) tick();
                check("bp_in_ready_held", 80'(bus_if.in_ready_o), 80'd0);
                hs_edge = cyc + 1;
                bus_if.out_ready_i = 1'b1;
            end
        join
        check("bp_second_accept_edge", 80'(a4 - hs_edge), 80'd1);
        drain();

        // Reset in the middle of RUN (round counter 10).
        send(K1, P1, 64'h3333DCD3213210D2, a0);
        repeat (12) tick();
        check("mid_busy", 80'(busy_o), 80'd1);
        rst_ni = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_in_ready",  80'(bus_if.in_ready_o),  80'd0);
        check("mid_rst_out_valid", 80'(bus_if.out_valid_o), 80'd0);
        check("mid_rst_ct",        80'(bus_if.ct_o),        80'd0);
        check("mid_rst_busy",      80'(busy_o),             80'd0);
        check("mid_rst_enc_data",  enc_data_o,              80'd0);
        check("mid_rst_strobes",   80'({enc_key_load_o, enc_data_load_o}), 80'd0);
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        send(K0, P0, 64'h5579C1387B228445, a0);
        drain();

        check("queue_empty", 80'(sb_q.size()), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
